// File: rtl/seed_pkg.sv
// Shared constants and phase encoding for the Toeplitz seed path.
// Imported by the seed RAM arbiter, the seed reader and the hash controller.
package seed_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 32;
    localparam int SEED_WORDS = 96;

    typedef enum logic [1:0] {
        FILL  = 2'b00,
        SERVE = 2'b01,
        DRAIN = 2'b10
    } phase_e;

endpackage

// File: rtl/seed_ram_arb.sv
// Arbitrates the single-port seed RAM between the loader (FILL) and the reader
// (SERVE/DRAIN), counts completed read passes and flags illegal writes.
module seed_ram_arb #(
    parameter int ADDR_W     = seed_pkg::ADDR_W,
    parameter int DATA_W     = seed_pkg::DATA_W,
    parameter int SEED_WORDS = seed_pkg::SEED_WORDS
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_gnt,
    input  logic              seed_release,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              seed_ready,
    output logic [7:0]        pass_cnt,
    output logic              wr_err
);

    import seed_pkg::*;

    localparam logic [ADDR_W-1:0] SEED_CNT  = ADDR_W'(SEED_WORDS);
    localparam logic [ADDR_W-1:0] SEED_LAST = ADDR_W'(SEED_WORDS - 1);

    phase_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              seed_ready_q, seed_ready_d;
    logic [7:0]        pass_cnt_q, pass_cnt_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_gnt_q, rd_gnt_d;

    logic              addr_ok;
    logic              rd_fall;
    logic              wr_gnt_c, rd_gnt_c, ram_en_c, ram_we_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c, rd_data_c;

    // rd_gnt_q doubles as the "previous rd_req" register: outside FILL the
    // grant equals the request, and it also marks when ram_rdata is valid.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        seed_ready_d = seed_ready_q;
        pass_cnt_d   = pass_cnt_q;
        wr_err_d     = wr_err_q;
        wr_gnt_c     = 1'b0;
        rd_gnt_c     = 1'b0;
        ram_en_c     = 1'b0;
        ram_we_c     = 1'b0;
        ram_addr_c   = '0;
        ram_wdata_c  = '0;
        rd_data_c    = '0;

        addr_ok = (wr_addr < SEED_CNT);
        rd_fall = rd_gnt_q && !rd_req;

        if (wr_req && ((state_q != FILL) || !addr_ok)) begin
            wr_err_d = 1'b1;
        end

        case (state_q)
            FILL: begin
                if (wr_req && addr_ok) begin
                    wr_gnt_c    = 1'b1;
                    ram_en_c    = 1'b1;
                    ram_we_c    = 1'b1;
                    ram_addr_c  = wr_addr;
                    ram_wdata_c = wr_data;
                    wr_cnt_d    = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == SEED_LAST) begin
                        state_d      = SERVE;
                        seed_ready_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                rd_gnt_c   = rd_req;
                ram_en_c   = rd_req;
                ram_addr_c = rd_addr;
                if (rd_gnt_q) begin
                    rd_data_c = ram_rdata;
                end
                if (rd_fall) begin
                    pass_cnt_d = pass_cnt_q + 8'd1;
                end
                // A release with the reader idle drops straight to FILL; an
                // active pass is allowed to finish in DRAIN first.
                if (seed_release) begin
                    seed_ready_d = 1'b0;
                    if (rd_req) begin
                        state_d = DRAIN;
                    end else begin
                        state_d    = FILL;
                        wr_cnt_d   = '0;
                        pass_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                rd_gnt_c   = rd_req;
                ram_en_c   = rd_req;
                ram_addr_c = rd_addr;
                if (rd_gnt_q) begin
                    rd_data_c = ram_rdata;
                end
                if (rd_fall) begin
                    state_d    = FILL;
                    wr_cnt_d   = '0;
                    pass_cnt_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        rd_gnt_d = rd_gnt_c;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wr_cnt_q     <= '0;
            seed_ready_q <= 1'b0;
            pass_cnt_q   <= '0;
            wr_err_q     <= 1'b0;
            rd_gnt_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            seed_ready_q <= seed_ready_d;
            pass_cnt_q   <= pass_cnt_d;
            wr_err_q     <= wr_err_d;
            rd_gnt_q     <= rd_gnt_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held so a
    // lingering request cannot reach the RAM.
    assign wr_gnt     = rst_n ? wr_gnt_c    : 1'b0;
    assign rd_gnt     = rst_n ? rd_gnt_c    : 1'b0;
    assign ram_en     = rst_n ? ram_en_c    : 1'b0;
    assign ram_we     = rst_n ? ram_we_c    : 1'b0;
    assign ram_addr   = rst_n ? ram_addr_c  : '0;
    assign ram_wdata  = rst_n ? ram_wdata_c : '0;
    assign rd_data    = rst_n ? rd_data_c   : '0;
    assign seed_ready = seed_ready_q;
    assign pass_cnt   = pass_cnt_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_seed_ram_arb.sv
// Self-checking bench for seed_ram_arb: phase-level reference model with a
// shadow memory, per-cycle comparison, plus literal checks on key events.
module tb_seed_ram_arb;

    logic        clk_in;
    logic        rst_n;
    logic        wr_req;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_gnt;
    logic        rd_req;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_gnt;
    logic        seed_release;
    logic        ram_en;
    logic        ram_we;
    logic [6:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        seed_ready;
    logic [7:0]  pass_cnt;
    logic        wr_err;

    int tests_run;
    int tests_failed;

    seed_ram_arb dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_gnt      (rd_gnt),
        .seed_release(seed_release),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .seed_ready  (seed_ready),
        .pass_cnt    (pass_cnt),
        .wr_err      (wr_err)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Behavioural single-port RAM with registered read data
    logic [31:0] ram_mem [0:127];
    initial begin
        for (int i = 0; i < 128; i++) ram_mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk_in) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: phase 0 = loading, 1 = serving, 2 = draining
    int          m_phase;
    int          m_written;
    logic        m_ready;
    int          m_passes;
    logic        m_err;
    logic        m_prev_read;
    logic [31:0] m_rd_exp;
    logic [31:0] shadow [0:127];

    initial begin
        logic acc;
        logic read_now;
        for (int i = 0; i < 128; i++) shadow[i] = '0;
        m_phase = 0; m_written = 0; m_ready = 0; m_passes = 0;
        m_err = 0; m_prev_read = 0; m_rd_exp = '0;
        forever begin
            @(negedge clk_in);
            if (!rst_n) begin
                checkOutput("rst_wr_gnt", wr_gnt, 0);
                checkOutput("rst_rd_gnt", rd_gnt, 0);
                checkOutput("rst_rd_data", rd_data, 0);
                checkOutput("rst_ram_en", ram_en, 0);
                checkOutput("rst_ram_we", ram_we, 0);
                checkOutput("rst_ram_addr", ram_addr, 0);
                checkOutput("rst_ram_wdata", ram_wdata, 0);
                checkOutput("rst_seed_ready", seed_ready, 0);
                checkOutput("rst_pass_cnt", pass_cnt, 0);
                checkOutput("rst_wr_err", wr_err, 0);
                m_phase = 0; m_written = 0; m_ready = 0; m_passes = 0;
                m_err = 0; m_prev_read = 0; m_rd_exp = '0;
            end else begin
                acc = wr_req && (wr_addr < 96);
                if (m_phase == 0) begin
                    checkOutput("m_wr_gnt", wr_gnt, acc);
                    checkOutput("m_ram_en", ram_en, acc);
                    checkOutput("m_ram_we", ram_we, acc);
                    if (acc) begin
                        checkOutput("m_ram_addr_w", ram_addr, wr_addr);
                        checkOutput("m_ram_wdata", ram_wdata, wr_data);
                    end
                    checkOutput("m_rd_gnt", rd_gnt, 0);
                    checkOutput("m_rd_data", rd_data, 0);
                end else begin
                    checkOutput("m_wr_gnt", wr_gnt, 0);
                    checkOutput("m_rd_gnt", rd_gnt, rd_req);
                    checkOutput("m_ram_en", ram_en, rd_req);
                    checkOutput("m_ram_we", ram_we, 0);
                    if (rd_req) checkOutput("m_ram_addr_r", ram_addr, rd_addr);
                    checkOutput("m_rd_data", rd_data, m_rd_exp);
                end
                checkOutput("m_seed_ready", seed_ready, m_ready);
                checkOutput("m_pass_cnt", pass_cnt, m_passes);
                checkOutput("m_wr_err", wr_err, m_err);

                // Advance the model with the inputs the DUT sees at the next edge
                read_now = (m_phase != 0) && rd_req;
                m_rd_exp = read_now ? shadow[rd_addr] : 32'h0;
                if (wr_req && (m_phase != 0 || wr_addr >= 96)) m_err = 1;
                if (m_phase == 0) begin
                    if (acc) begin
                        shadow[wr_addr] = wr_data;
                        m_written++;
                        if (m_written == 96) begin
                            m_phase = 1;
                            m_ready = 1;
                        end
                    end
                end else if (m_phase == 1) begin
                    if (m_prev_read && !rd_req) m_passes = (m_passes + 1) % 256;
                    if (seed_release) begin
                        m_ready = 0;
                        if (rd_req) m_phase = 2;
                        else begin
                            m_phase = 0; m_written = 0; m_passes = 0;
                        end
                    end
                end else begin
                    if (m_prev_read && !rd_req) begin
                        m_phase = 0; m_written = 0; m_passes = 0;
                    end
                end
                m_prev_read = read_now;
            end
        end
    end

    task automatic applyStimulus(input logic wr_r, input int wa, input logic [31:0] wd,
                                 input logic rr, input int ra, input logic rel);
        wr_req       = wr_r;
        wr_addr      = 7'(wa);
        wr_data      = wd;
        rd_req       = rr;
        rd_addr      = 7'(ra);
        seed_release = rel;
        @(negedge clk_in);
    endtask

    task automatic advance();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int gnt_seen;
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;

        // Reset with a pending write: nothing may leak to the RAM
        applyStimulus(1, 0, 32'h1234_5678, 1, 0, 0);
        checkOutput("rst_gate_wr_gnt", wr_gnt, 0);
        checkOutput("rst_gate_ram_en", ram_en, 0);
        advance();
        rst_n = 1'b1;

        // Out-of-range write in FILL
        applyStimulus(1, 100, 32'hBAD0_0100, 0, 0, 0);
        checkOutput("oob_wr_gnt", wr_gnt, 0);
        advance();

        // Full fill; reads during FILL must be ignored
        gnt_seen = 0;
        for (int i = 0; i < 96; i++) begin
            applyStimulus(1, i, (i == 5) ? 32'hDEAD_BEEF : 32'hA500_0000 + i, i < 90, i, 0);
            if (wr_gnt) gnt_seen++;
            if (i == 0)  checkOutput("wr_err_sticky", wr_err, 1);
            if (i == 10) checkOutput("fill_rd_gnt", rd_gnt, 0);
            if (i == 10) checkOutput("fill_rd_data", rd_data, 0);
            if (i == 95) checkOutput("ready_before_last", seed_ready, 0);
            advance();
        end
        checkOutput("fill_gnt_count", gnt_seen, 96);

        // Write attempt in SERVE
        applyStimulus(1, 3, 32'hFFFF_FFFF, 0, 0, 0);
        checkOutput("ready_after_fill", seed_ready, 1);
        checkOutput("serve_wr_gnt", wr_gnt, 0);
        checkOutput("serve_ram_we", ram_we, 0);
        advance();

        // Three full passes, two words per address cadence of 192 cycles
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 192; i++) begin
                applyStimulus((p == 0 && i == 2), 3, 32'h0BAD_0003, 1, (i + 5) % 96, 0);
                if (p == 0 && i == 0) checkOutput("read5_addr", ram_addr, 5);
                if (p == 0 && i == 1) checkOutput("read5_data", rd_data, 32'hDEAD_BEEF);
                if (p == 0 && i == 2) checkOutput("conflict_addr", ram_addr, 7);
                if (p == 0 && i == 2) checkOutput("conflict_wr_gnt", wr_gnt, 0);
                if (p == 0 && i == 95) checkOutput("read3_intact", rd_data, 32'hA500_0003);
                advance();
            end
            applyStimulus(0, 0, 0, 0, 0, 0);
            advance();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("three_passes", pass_cnt, 3);
        advance();

        // Release mid-pass: drain, then back to FILL
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 1, i, i == 4);
            if (i == 5) checkOutput("drain_ready_low", seed_ready, 0);
            if (i == 5) checkOutput("drain_rd_gnt", rd_gnt, 1);
            if (i == 6) checkOutput("drain_rd_data", rd_data, 32'hDEAD_BEEF);
            advance();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("drain_pass_hold", pass_cnt, 3);
        advance();
        applyStimulus(0, 0, 0, 1, 5, 1);
        checkOutput("refill_pass_clr", pass_cnt, 0);
        checkOutput("refill_rd_gnt", rd_gnt, 0);
        advance();

        // Partial refill, then reset mid-fill
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, i, 32'hC000_0000 + i, 0, 0, i == 20);
            if (i == 0) checkOutput("refill_wr_gnt", wr_gnt, 1);
            advance();
        end
        rst_n   = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 7'd40;
        #1;
        checkOutput("async_rst_wr_gnt", wr_gnt, 0);
        checkOutput("async_rst_ram_en", ram_en, 0);
        checkOutput("async_rst_ram_wdata", ram_wdata, 0);
        checkOutput("async_rst_wr_err", wr_err, 0);
        advance();
        rst_n = 1'b1;

        // Full 96 writes needed again, descending order
        for (int i = 0; i < 96; i++) begin
            applyStimulus(1, 95 - i, 32'h5EED_0000 + i, 0, 0, 0);
            if (i == 95) checkOutput("rst_refill_not_ready", seed_ready, 0);
            advance();
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("rst_refill_ready", seed_ready, 1);
        advance();
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("reread_addr0", rd_data, 32'h5EED_005F);
        advance();

        // Reader idle + release in SERVE: straight to FILL
        applyStimulus(0, 0, 0, 0, 0, 1);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("idle_release_ready", seed_ready, 0);
        checkOutput("idle_release_pass", pass_cnt, 0);
        advance();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
